// File: rtl/load_store_unit.sv
// In-order load/store unit with a fixed 3-cycle response latency.
// Define LSU_SUBWORD_STORE_EN to enable byte/halfword stores via read-modify-write.
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_en,
   output logic        mem_we,
   input  logic [31:0] mem_dout
);
   typedef struct packed {
      logic       valid;
      logic       we;
      logic [1:0] size;
      logic [1:0] off;
      logic       sgn;
      logic       err;
   } meta_t;

   logic [29:0] idx;
   logic [1:0]  off;
   logic        dec_err;
   logic        idle_rdy;
   logic        accept;
   logic        legal;
   meta_t       s1_d, s1_q, s2_q, s3_q;
   logic [31:0] rdata_d, rdata_q;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        rmw_wr;
   logic [29:0] rmw_idx;
   logic [31:0] rmw_din;

   assign idx    = req_addr[31:2];
   assign off    = req_addr[1:0];
   assign accept = req_valid & req_ready;
   assign legal  = accept & ~dec_err;

   always_comb begin
      dec_err = 1'b0;
      unique case (req_size)
         2'b00:   dec_err = 1'b0;
         2'b01:   dec_err = off[0];
         2'b10:   dec_err = (off != 2'b00);
         default: dec_err = 1'b1;
      endcase
      if ({2'b00, idx} >= MEM_WORDS) dec_err = 1'b1;
`ifndef LSU_SUBWORD_STORE_EN
      if (req_we && req_size != 2'b10) dec_err = 1'b1;
`endif
   end

   always_comb begin
      s1_d = '{valid: accept, we: req_we, size: req_size,
               off: off, sgn: req_signed, err: dec_err};
   end

   // Read data for the request now in stage 2 arrives this cycle.
   always_comb begin
      ld_byte = mem_dout[{s2_q.off, 3'b000} +: 8];
      ld_half = mem_dout[{s2_q.off[1], 4'b0000} +: 16];
      rdata_d = '0;
      if (s2_q.valid && !s2_q.we && !s2_q.err) begin
         unique case (s2_q.size)
            2'b00:   rdata_d = {{24{s2_q.sgn & ld_byte[7]}}, ld_byte};
            2'b01:   rdata_d = {{16{s2_q.sgn & ld_half[15]}}, ld_half};
            default: rdata_d = mem_dout;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         rdata_q <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         rdata_q <= rdata_d;
      end
   end

`ifdef LSU_SUBWORD_STORE_EN
   typedef enum logic [1:0] {IDLE, RMW_WAIT, RMW_WRITE} state_e;

   state_e      state_q, state_d;
   logic [29:0] rmw_idx_q, rmw_idx_d;
   logic [15:0] rmw_wd_q, rmw_wd_d;
   logic [1:0]  rmw_off_q, rmw_off_d;
   logic        rmw_byte_q, rmw_byte_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         rmw_idx_q  <= '0;
         rmw_wd_q   <= '0;
         rmw_off_q  <= '0;
         rmw_byte_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rmw_idx_q  <= rmw_idx_d;
         rmw_wd_q   <= rmw_wd_d;
         rmw_off_q  <= rmw_off_d;
         rmw_byte_q <= rmw_byte_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rmw_idx_d  = rmw_idx_q;
      rmw_wd_d   = rmw_wd_q;
      rmw_off_d  = rmw_off_q;
      rmw_byte_d = rmw_byte_q;
      rmw_din    = mem_dout;
      if (rmw_byte_q)
         rmw_din[{rmw_off_q, 3'b000} +: 8] = rmw_wd_q[7:0];
      else
         rmw_din[{rmw_off_q[1], 4'b0000} +: 16] = rmw_wd_q;
      unique case (state_q)
         IDLE: begin
            if (legal && req_we && req_size != 2'b10) begin
               state_d    = RMW_WAIT;
               rmw_idx_d  = idx;
               rmw_wd_d   = req_wdata[15:0];
               rmw_off_d  = off;
               rmw_byte_d = (req_size == 2'b00);
            end
         end
         RMW_WAIT:  state_d = RMW_WRITE;
         RMW_WRITE: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   assign idle_rdy = (state_q == IDLE);
   assign rmw_wr   = (state_q == RMW_WRITE);
   assign rmw_idx  = rmw_idx_q;
`else
   assign idle_rdy = 1'b1;
   assign rmw_wr   = 1'b0;
   assign rmw_idx  = '0;
   assign rmw_din  = '0;
`endif

   // A sub-word store's first access is the read half of its RMW.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (!reset) begin
         if (rmw_wr) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {2'b00, rmw_idx};
            mem_din  = rmw_din;
         end else if (legal) begin
            mem_en   = 1'b1;
            mem_we   = req_we & (req_size == 2'b10);
            mem_addr = {2'b00, idx};
            mem_din  = mem_we ? req_wdata : '0;
         end
      end
   end

   assign req_ready = ~reset & idle_rdy;
   assign rsp_valid = ~reset & s3_q.valid;
   assign rsp_err   = ~reset & s3_q.valid & s3_q.err;
   assign rsp_rdata = reset ? '0 : rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random traffic
// against a word-array reference model and a 2-cycle-latency memory.
module tb_load_store_unit;
  localparam int MW = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_dout = '0;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  logic [31:0] mem_arr [MW];
  logic [31:0] rd1 = '0;

  always @(posedge clock) begin
    if (mem_en && mem_addr < MW) begin
      if (mem_we) mem_arr[mem_addr] <= mem_din;
      rd1 <= mem_arr[mem_addr];
    end
    mem_dout <= rd1;
  end

  logic [31:0] ref_mem [MW];
  bit          rv [8];
  logic [31:0] rd [8];
  bit          re [8];
  bit          blk [8];
  bit          pend;
  int          pend_cyc;
  int unsigned pend_idx;
  logic [31:0] pend_val;
  int          cyc;
  int          checks;
  int          passes;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h at cycle %0d",
                tag, got, exp, cyc);
  endtask

  function automatic bit is_err(input bit we, input logic [1:0] sz,
                                input logic [31:0] a);
    int unsigned wi;
    wi = a >> 2;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    if (wi >= MW) return 1'b1;
`ifndef LSU_SUBWORD_STORE_EN
    if (we && sz != 2'd2) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w,
    input logic [1:0] sz, input logic [1:0] o, input bit sg);
    logic [31:0] sh;
    sh = w >> (8 * o);
    if (sz == 2'd0) begin
      sh = sh & 32'hFF;
      if (sg && sh >= 32'h80) sh = sh | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = sh & 32'hFFFF;
      if (sg && sh >= 32'h8000) sh = sh | 32'hFFFF_0000;
    end
    return sh;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w,
    input logic [31:0] wd, input logic [1:0] sz, input logic [1:0] o);
    logic [31:0] m;
    m = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    return (w & ~(m << (8 * o))) | ((wd & m) << (8 * o));
  endfunction

  task automatic cycle(input bit rst, input bit v, input bit we,
    input logic [1:0] sz, input bit sg, input logic [31:0] a,
    input logic [31:0] wd);
    bit          exp_rdy, acc, e, en, wen;
    int          s, n;
    int unsigned wi;
    logic [31:0] w, r, ea, ed;
    reset = rst; req_valid = v; req_we = we; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    #3;
    s = cyc % 8;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      for (int i = 0; i < 8; i++) begin
        rv[i] = 0; blk[i] = 0;
      end
      pend = 0;
    end else begin
      exp_rdy = !blk[s];
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(rv[s]));
      if (rv[s]) begin
        chk("rsp_rdata", rsp_rdata, rd[s]);
        chk("rsp_err", 32'(rsp_err), 32'(re[s]));
        last_rdata = rsp_rdata;
      end
      rv[s] = 0; blk[s] = 0;
      wi = a >> 2;
      e = is_err(we, sz, a);
      acc = v && exp_rdy;
      en = 0; wen = 0; ea = 0; ed = 0;
      if (acc && !e) begin
        en = 1; ea = wi;
        if (we && sz == 2'd2) begin
          wen = 1; ed = wd;
        end
      end else if (pend && pend_cyc == cyc) begin
        en = 1; wen = 1; ea = pend_idx; ed = pend_val;
        ref_mem[pend_idx] = pend_val;
        pend = 0;
      end
      chk("mem_en", 32'(mem_en), 32'(en));
      if (en) begin
        chk("mem_we", 32'(mem_we), 32'(wen));
        chk("mem_addr", mem_addr, ea);
        if (wen) chk("mem_din", mem_din, ed);
      end
      if (acc) begin
        r = 0;
        if (!e) begin
          w = ref_mem[wi];
          if (!we) r = load_val(w, sz, a[1:0], sg);
          else if (sz == 2'd2) ref_mem[wi] = wd;
          else begin
            pend = 1; pend_cyc = cyc + 2; pend_idx = wi;
            pend_val = merge(w, wd, sz, a[1:0]);
            blk[(cyc + 1) % 8] = 1;
            blk[(cyc + 2) % 8] = 1;
          end
        end
        n = (cyc + 3) % 8;
        rv[n] = 1; rd[n] = r; re[n] = e;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 2'd0, 0, 0, 0);
  endtask

  initial begin
    cyc = 0; checks = 0; passes = 0; pend = 0; last_rdata = 0;
    for (int i = 0; i < MW; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    cycle(1, 0, 0, 2'd0, 0, 0, 0);
    cycle(1, 0, 0, 2'd0, 0, 0, 0);

    cycle(0, 1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    cycle(0, 1, 0, 2'd2, 0, 32'h10, 0);
    idle(3);
    chk("ld_0x10", last_rdata, 32'hDEADBEEF);

    cycle(0, 1, 1, 2'd2, 0, 32'h20, 32'h80FF7F01);
    cycle(0, 1, 0, 2'd0, 1, 32'h22, 0);
    idle(3);
    chk("lb_s_0x22", last_rdata, 32'hFFFFFFFF);
    cycle(0, 1, 0, 2'd0, 0, 32'h21, 0);
    idle(3);
    chk("lb_u_0x21", last_rdata, 32'h0000007F);
    cycle(0, 1, 0, 2'd1, 1, 32'h22, 0);
    idle(3);
    chk("lh_s_0x22", last_rdata, 32'hFFFF80FF);

    cycle(0, 1, 0, 2'd1, 0, 32'h3, 0);
    cycle(0, 1, 0, 2'd2, 0, 32'h2, 0);
    cycle(0, 1, 0, 2'd2, 0, 32'(4 * MW), 0);
    idle(3);

    cycle(0, 1, 1, 2'd2, 0, 32'h40, 32'h11223344);
    cycle(0, 1, 1, 2'd0, 0, 32'h41, 32'h5566_77AA);
    cycle(0, 1, 0, 2'd2, 0, 32'h40, 0);
    idle(4);
    cycle(0, 1, 0, 2'd2, 0, 32'h40, 0);
    idle(3);
`ifdef LSU_SUBWORD_STORE_EN
    chk("rmw_0x40", last_rdata, 32'h1122AA44);
`else
    chk("nosub_0x40", last_rdata, 32'h11223344);
`endif

    cycle(0, 1, 1, 2'd0, 0, 32'h42, 32'hBB);
    cycle(1, 0, 0, 2'd0, 0, 0, 0);
    idle(2);
    cycle(0, 1, 0, 2'd2, 0, 32'h40, 0);
    idle(3);
`ifdef LSU_SUBWORD_STORE_EN
    chk("rmw_rst_0x40", last_rdata, 32'h1122AA44);
`else
    chk("nosub_rst_0x40", last_rdata, 32'h11223344);
`endif

    cycle(0, 1, 0, 2'd2, 0, 32'h10, 0);
    cycle(0, 1, 0, 2'd2, 0, 32'h20, 0);
    cycle(0, 1, 0, 2'd2, 0, 32'h40, 0);
    cycle(1, 0, 0, 2'd0, 0, 0, 0);
    idle(6);

    repeat (500) begin
      int unsigned ri;
      logic [1:0]  ro;
      logic [31:0] ra;
      ri = ($urandom_range(0, 7) == 0) ?
           MW - 1 + $urandom_range(0, 2) : $urandom_range(0, 15);
      ro = 2'($urandom_range(0, 3));
      ra = {ri[29:0], ro};
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ra, $urandom);
    end
    idle(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
